flash_burst_reader: RTL and testbench
=====================================

# flash_burst_reader

Parametrised Avalon-MM flash read master and the successor to the single-word flash read handshake tracker. It accepts a start command with a word address and a word count, issues one burst read to the flash controller, and streams each returned word out with an index. It reports completion, and it reports a timeout if the flash stalls. It sits between the audio/sample playback FSM and the on-board flash IP.

## Interface
Parameters:
- `ADDR_W`, 23: flash word-address width.
- `DATA_W`, 32: flash data width.
- `MAX_BURST`, 8: largest burst in words; a power of two, at least 1. `BC_W = $clog2(MAX_BURST)+1`.
- `TIMEOUT`, 1023: idle cycles allowed per handshake phase before abort; at least 1.

Ports:
- `inclk`  in  1  clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word address.
- `num_words`  in  BC_W  words requested; 0 is legal; values above MAX_BURST are clamped.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  high only together with `done` when the command ended by timeout.
- `out_data`  out  DATA_W  captured word.
- `out_index`  out  BC_W  beat number of `out_data`, counting from 0.
- `out_valid`  out  1  one-cycle pulse per captured word.
- `flash_mem_read`  out  1  Avalon read request.
- `flash_mem_address`  out  ADDR_W  burst start address.
- `flash_mem_burstcount`  out  BC_W  burst length.
- `flash_mem_waitrequest`  in  1  slave stall.
- `flash_mem_readdata`  in  DATA_W  returned data.
- `flash_mem_readdatavalid`  in  1  returned-data qualifier.

## Operation
- States are IDLE, REQ, DATA and DONE.
- IDLE:
  - `start`=1 and `num_words`=0 → DONE. No bus access is made.
  - `start`=1 and `num_words`>0 → REQ. Latch `start_addr` and `n = min(num_words, MAX_BURST)`. Clear the beat counter and the timeout counter.
- REQ:
  - `flash_mem_read`=1, with the latched address and burstcount, are held stable.
  - `waitrequest`=0 → DATA. This is the accepting edge, and `read` drops on the next cycle.
  - Timeout → DONE with `error`.
- DATA:
  - Each `readdatavalid`=1 captures `readdata` into `out_data` and the current beat count into `out_index`, pulses `out_valid`, increments the beat count and clears the timeout counter.
  - When the captured beat is beat n-1 → DONE.
  - Timeout → DONE with `error`.
- DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- Timeout counter:
  - Increments every cycle in REQ or DATA in which no progress is made.
  - Progress means the request is accepted (REQ) or a beat arrives (DATA).
  - Timeout fires when the count reaches TIMEOUT. `error` is registered alongside the DONE transition.
- `readdatavalid` outside DATA is ignored, and so are beats beyond n; neither produces `out_valid`.
- `start` outside IDLE is ignored. There is no queueing.
- Abort on timeout drops `read` immediately. This is a deliberate protocol exception for recovery only.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `error`, `out_valid` and `flash_mem_read` = 0; `out_data`, `out_index`, `flash_mem_address` and `flash_mem_burstcount` = 0.
- Assertion of `rst_n` takes effect immediately, in any state, and discards the in-flight burst.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Command accepted at edge E:
  - `busy` and `flash_mem_read` are high from E+1.
  - With `waitrequest` always 0, `read` is high for exactly one cycle.
- Beat sampled at edge B → `out_valid` is high during cycle B+1.
- Last beat: `out_valid` and `done` are high in the same cycle. `busy` is 0 on the following cycle.
- `num_words`=0: `done` is high during E+1, and `busy` is high only in that cycle.
- Minimum back-to-back interval: a new `start` is accepted in the first IDLE cycle after DONE.

## Structure
- Shared header `flash_pkg.vh`:
  - state encodings IDLE=2'd0, REQ=2'd1, DATA=2'd2, DONE=2'd3;
  - the `BC_W` computation macro.
- Sub-module `flash_timeout_counter`:
  - parameter `TIMEOUT`;
  - inputs `inclk`, `rst_n`, `clear`, `enable`;
  - output `expired`.
- All remaining logic stays in `flash_burst_reader`.

## Test plan
- `start_addr`=0x000100, `num_words`=4, `waitrequest` low, beats on consecutive cycles → one `read` cycle with address 0x000100 and burstcount 4; four `out_valid` pulses with indices 0 to 3 and the matching data; `done`=1 on index 3; `error`=0.
- `waitrequest` held high for 5 cycles, then 2 beats with 3 idle cycles between them (`num_words`=2) → `read` and the address stay stable for 6 cycles; 2 outputs; `done`; no error.
- `num_words`=0 → no `read`; `done` in the cycle after `start`; `busy` for 1 cycle.
- `num_words`=12 with MAX_BURST=8 → burstcount 8; exactly 8 outputs; a 9th `readdatavalid` produces no output.
- TIMEOUT=16, no `readdatavalid` after acceptance → `done`=`error`=1 after 16 stalled cycles, then IDLE; a new `start` is accepted.
- `rst_n` pulsed low mid-burst after 2 of 4 beats → all outputs are 0 immediately; state is IDLE; later stray beats produce no `out_valid`.

Source files
------------

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared state encoding and burst-count width helper for the flash burst reader
package flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int bc_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/flash_timeout_counter.sv
// rtl/flash_timeout_counter.sv - stall counter; expired flags the stalled cycle whose count reaches TIMEOUT
module flash_timeout_counter #(
  parameter int TIMEOUT = 1023
) (
  input  logic inclk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Fires on the stalled cycle whose closing edge would make the count equal TIMEOUT.
  assign expired = enable && !clear && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/flash_burst_reader.sv
// rtl/flash_burst_reader.sv - Avalon-MM burst read master streaming indexed words with done/timeout reporting
module flash_burst_reader
  import flash_pkg::*;
#(
  parameter  int ADDR_W    = 23,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 8,
  parameter  int TIMEOUT   = 1023,
  localparam int BC_W      = bc_w(MAX_BURST)
) (
  input  logic              inclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [BC_W-1:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] out_data,
  output logic [BC_W-1:0]   out_index,
  output logic              out_valid,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [BC_W-1:0]   flash_mem_burstcount,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [BC_W-1:0]   r_n;
  logic [BC_W-1:0]   r_beat;
  logic              r_error;
  logic [DATA_W-1:0] r_out_data;
  logic [BC_W-1:0]   r_out_index;
  logic              r_out_valid;

  logic              w_progress;
  logic              w_enable;
  logic              w_clear;
  logic              w_beat;
  logic              w_last;
  logic              w_expired;
  logic              w_abort;
  logic              w_accept;
  logic [BC_W-1:0]   w_clamped;

  assign w_beat     = (r_state == ST_DATA) && flash_mem_readdatavalid;
  assign w_progress = ((r_state == ST_REQ) && !flash_mem_waitrequest) || w_beat;
  assign w_enable   = ((r_state == ST_REQ) || (r_state == ST_DATA)) && !w_progress;
  assign w_clear    = (r_state == ST_IDLE) || w_progress;
  assign w_last     = w_beat && (r_beat == (r_n - BC_W'(1)));
  assign w_accept   = (r_state == ST_IDLE) && start && (num_words != '0);
  assign w_clamped  = (num_words > BC_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : num_words;

  flash_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .inclk   (inclk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .enable  (w_enable),
    .expired (w_expired)
  );

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (num_words == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (!flash_mem_waitrequest) begin
          w_next = ST_DATA;
        end else if (w_expired) begin
          w_next  = ST_DONE;
          w_abort = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_last) begin
          w_next = ST_DONE;
        end else if (w_expired) begin
          w_next  = ST_DONE;
          w_abort = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_n         <= '0;
      r_beat      <= '0;
      r_error     <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_error     <= w_abort;
      r_out_valid <= w_beat;
      if (w_accept) begin
        r_addr <= start_addr;
        r_n    <= w_clamped;
        r_beat <= '0;
      end
      if (w_beat) begin
        r_out_data  <= flash_mem_readdata;
        r_out_index <= r_beat;
        r_beat      <= r_beat + BC_W'(1);
      end
    end
  end

  assign busy                 = (r_state != ST_IDLE);
  assign done                 = (r_state == ST_DONE);
  assign error                = r_error;
  assign out_data             = r_out_data;
  assign out_index            = r_out_index;
  assign out_valid            = r_out_valid;
  assign flash_mem_read       = (r_state == ST_REQ);
  assign flash_mem_address    = r_addr;
  assign flash_mem_burstcount = r_n;

endmodule

// File: tb/tb_flash_burst_reader.sv
// tb/tb_flash_burst_reader.sv - directed self-checking bench for flash_burst_reader
module tb_flash_burst_reader;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int BC_W   = 4;

  logic              inclk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [BC_W-1:0]   num_words;
  logic              busy, done, error, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [BC_W-1:0]   out_index;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [BC_W-1:0]   flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic [DATA_W-1:0] flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  flash_burst_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (8),
    .TIMEOUT   (16)
  ) dut (
    .inclk                   (inclk),
    .rst_n                   (rst_n),
    .start                   (start),
    .start_addr              (start_addr),
    .num_words               (num_words),
    .busy                    (busy),
    .done                    (done),
    .error                   (error),
    .out_data                (out_data),
    .out_index               (out_index),
    .out_valid               (out_valid),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_burstcount    (flash_mem_burstcount),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid)
  );

  always #5 inclk = ~inclk;

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_read"},  64'(flash_mem_read), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    num_words = '0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdata = '0;
    flash_mem_readdatavalid = 1'b0;
    repeat (3) step();

    chk_idle_outputs("rst");
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_addr", 64'(flash_mem_address), 64'd0);
    chk("rst_bc", 64'(flash_mem_burstcount), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic 4-word burst, no stalls, back-to-back beats
    start = 1'b1; start_addr = 23'h000100; num_words = 4'd4;
    step();
    start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_read", 64'(flash_mem_read), 64'd1);
    chk("t1_addr", 64'(flash_mem_address), 64'h100);
    chk("t1_bc", 64'(flash_mem_burstcount), 64'd4);
    step();
    chk("t1_read_drop", 64'(flash_mem_read), 64'd0);
    for (int i = 0; i < 4; i++) begin
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata = 32'hA000_0000 + 32'(i);
      step();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_index", 64'(out_index), 64'(i));
      chk("t1_data", 64'(out_data), 64'hA000_0000 + 64'(i));
      chk("t1_done", 64'(done), (i == 3) ? 64'd1 : 64'd0);
    end
    flash_mem_readdatavalid = 1'b0;
    chk("t1_error", 64'(error), 64'd0);
    step();
    chk_idle_outputs("t1_end");

    // Waitrequest held 5 cycles, 2 beats with 3 idle cycles between them
    start = 1'b1; start_addr = 23'h002345; num_words = 4'd2;
    flash_mem_waitrequest = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t2_read_held", 64'(flash_mem_read), 64'd1);
      chk("t2_addr_held", 64'(flash_mem_address), 64'h2345);
      if (k == 5) flash_mem_waitrequest = 1'b0;
      step();
    end
    chk("t2_read_drop", 64'(flash_mem_read), 64'd0);
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hB0;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("t2_v0", 64'(out_valid), 64'd1);
    chk("t2_i0", 64'(out_index), 64'd0);
    chk("t2_d0", 64'(out_data), 64'hB0);
    chk("t2_done0", 64'(done), 64'd0);
    repeat (3) begin
      step();
      chk("t2_gap_valid", 64'(out_valid), 64'd0);
      chk("t2_gap_busy", 64'(busy), 64'd1);
    end
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hB1;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("t2_v1", 64'(out_valid), 64'd1);
    chk("t2_i1", 64'(out_index), 64'd1);
    chk("t2_d1", 64'(out_data), 64'hB1);
    chk("t2_done1", 64'(done), 64'd1);
    chk("t2_error", 64'(error), 64'd0);
    step();
    chk_idle_outputs("t2_end");

    // Zero-length command
    start = 1'b1; start_addr = 23'h000777; num_words = 4'd0;
    step();
    start = 1'b0;
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_read", 64'(flash_mem_read), 64'd0);
    chk("t3_error", 64'(error), 64'd0);
    step();
    chk_idle_outputs("t3_end");

    // Clamp 12 -> 8, then a 9th beat must be ignored
    start = 1'b1; start_addr = 23'h7FFFFF; num_words = 4'd12;
    step();
    start = 1'b0;
    chk("t4_bc", 64'(flash_mem_burstcount), 64'd8);
    chk("t4_addr", 64'(flash_mem_address), 64'h7FFFFF);
    step();
    for (int i = 0; i < 8; i++) begin
      flash_mem_readdatavalid = 1'b1;
      flash_mem_readdata = 32'hC0 + 32'(i);
      step();
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_index", 64'(out_index), 64'(i));
      chk("t4_data", 64'(out_data), 64'hC0 + 64'(i));
    end
    chk("t4_done", 64'(done), 64'd1);
    flash_mem_readdata = 32'hDEAD;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("t4_extra_valid", 64'(out_valid), 64'd0);
    chk("t4_extra_data", 64'(out_data), 64'hC7);
    chk("t4_extra_busy", 64'(busy), 64'd0);

    // Timeout after acceptance: 16 stalled DATA cycles
    start = 1'b1; start_addr = 23'h000200; num_words = 4'd3;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      chk("t5_wait_done", 64'(done), 64'd0);
      chk("t5_wait_busy", 64'(busy), 64'd1);
      step();
    end
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_error", 64'(error), 64'd1);
    step();
    chk_idle_outputs("t5_idle");
    start = 1'b1; start_addr = 23'h000005; num_words = 4'd1;
    step();
    start = 1'b0;
    chk("t5_restart_read", 64'(flash_mem_read), 64'd1);
    chk("t5_restart_addr", 64'(flash_mem_address), 64'h5);
    step();
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'h1234_5678;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("t5_restart_valid", 64'(out_valid), 64'd1);
    chk("t5_restart_data", 64'(out_data), 64'h1234_5678);
    chk("t5_restart_done", 64'(done), 64'd1);
    chk("t5_restart_error", 64'(error), 64'd0);
    step();

    // Asynchronous reset mid-burst after 2 of 4 beats
    start = 1'b1; start_addr = 23'h000040; num_words = 4'd4;
    step();
    start = 1'b0;
    step();
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hE0;
    step();
    flash_mem_readdata = 32'hE1;
    step();
    flash_mem_readdatavalid = 1'b0;
    chk("t6_pre_index", 64'(out_index), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_index", 64'(out_index), 64'd0);
    chk("t6_rst_addr", 64'(flash_mem_address), 64'd0);
    chk("t6_rst_bc", 64'(flash_mem_burstcount), 64'd0);
    step();
    rst_n = 1'b1;
    flash_mem_readdatavalid = 1'b1; flash_mem_readdata = 32'hE2;
    repeat (2) begin
      step();
      chk("t6_stray_valid", 64'(out_valid), 64'd0);
      chk("t6_stray_busy", 64'(busy), 64'd0);
    end
    flash_mem_readdatavalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
